// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: FSM state encoding, UART
// register addresses and the "no destination" register tag.
package mem_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RD_SETUP,
      RD_SAMPLE,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD
`ifdef MEM_UART_EN
      , U_RD
      , U_WR
`endif
   } state_t;

   localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
   localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;
   localparam logic [3:0]  NO_REG         = 4'b1111;

endpackage

// File: rtl/mem_sram_fsm.sv
// Access sequencer: state register, SRAM/UART strobe generation and the
// upstream stall signal. The UART states exist only when MEM_UART_EN is defined.
module mem_sram_fsm
   import mem_pkg::*;
(
   input  logic   clk,
   input  logic   rst,
   input  logic   start_rd,
   input  logic   start_wr,
`ifdef MEM_UART_EN
   input  logic   start_urd,
   input  logic   start_uwr,
   output logic   u_last,
   output logic   uart_rdn,
   output logic   uart_wrn,
`endif
   output state_t state,
   output logic   mem_busy,
   output logic   ram_en_n,
   output logic   ram_oe_n,
   output logic   ram_we_n,
   output logic   ram_dout_oe
);

   state_t state_reg, state_next;
   logic   busy;

`ifdef MEM_UART_EN
   // Counts the two strobe cycles of a UART access; set on the second one.
   logic u_cnt_reg;
   always_ff @(posedge clk) begin
      if (rst)
         u_cnt_reg <= 1'b0;
      else if (state_reg == U_RD || state_reg == U_WR)
         u_cnt_reg <= ~u_cnt_reg;
      else
         u_cnt_reg <= 1'b0;
   end
   assign u_last = u_cnt_reg;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      busy        = 1'b0;
      ram_en_n    = 1'b1;
      ram_oe_n    = 1'b1;
      ram_we_n    = 1'b1;
      ram_dout_oe = 1'b0;
`ifdef MEM_UART_EN
      uart_rdn    = 1'b1;
      uart_wrn    = 1'b1;
`endif
      case (state_reg)
         IDLE: begin
            if (start_rd)
               state_next = RD_SETUP;
            else if (start_wr)
               state_next = WR_SETUP;
`ifdef MEM_UART_EN
            else if (start_urd)
               state_next = U_RD;
            else if (start_uwr)
               state_next = U_WR;
`endif
            busy = (state_next != IDLE);
         end
         RD_SETUP: begin
            ram_en_n   = 1'b0;
            ram_oe_n   = 1'b0;
            busy       = 1'b1;
            state_next = RD_SAMPLE;
         end
         RD_SAMPLE: begin
            ram_en_n   = 1'b0;
            ram_oe_n   = 1'b0;
            state_next = IDLE;
         end
         WR_SETUP: begin
            ram_en_n    = 1'b0;
            ram_dout_oe = 1'b1;
            busy        = 1'b1;
            state_next  = WR_PULSE;
         end
         WR_PULSE: begin
            ram_en_n    = 1'b0;
            ram_we_n    = 1'b0;
            ram_dout_oe = 1'b1;
            busy        = 1'b1;
            state_next  = WR_HOLD;
         end
         WR_HOLD: begin
            ram_en_n    = 1'b0;
            ram_dout_oe = 1'b1;
            state_next  = IDLE;
         end
`ifdef MEM_UART_EN
         // Stall drops on the final strobe cycle so upstream advances with the result.
         U_RD: begin
            uart_rdn   = 1'b0;
            busy       = ~u_cnt_reg;
            state_next = u_cnt_reg ? IDLE : U_RD;
         end
         U_WR: begin
            uart_wrn    = 1'b0;
            ram_dout_oe = 1'b1;
            busy        = ~u_cnt_reg;
            state_next  = u_cnt_reg ? IDLE : U_WR;
         end
`endif
         default: state_next = IDLE;
      endcase
   end

   assign state    = state_reg;
   assign mem_busy = busy & ~rst;

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: request latch, address decode and the MEM/WB
// result registers. Optional memory-mapped UART enabled by MEM_UART_EN.
module mem_access
   import mem_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              memread_in,
   input  logic              memwrite_in,
   input  logic              controlwb_in,
   input  logic [DATA_W-1:0] alu_in,
   input  logic [DATA_W-1:0] wdata_in,
   input  logic [3:0]        wreg_in,
   output logic              mem_busy,
   output logic              wb_en,
   output logic [DATA_W-1:0] wb_data,
   output logic [3:0]        wb_reg,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_dout,
   input  logic [DATA_W-1:0] ram_din,
   output logic              ram_dout_oe,
   output logic              ram_en_n,
   output logic              ram_oe_n,
   output logic              ram_we_n
`ifdef MEM_UART_EN
   ,
   output logic              uart_rdn,
   output logic              uart_wrn,
   input  logic              uart_data_ready,
   input  logic              uart_tbre,
   input  logic              uart_tsre
`endif
);

   state_t            state;
   logic              start_rd, start_wr, start_any;
   logic [DATA_W-1:0] pass_data;
   logic [DATA_W-1:0] addr_reg, data_reg;
   logic [3:0]        tag_reg;
   logic              en_reg;

`ifdef MEM_UART_EN
   logic is_data, is_stat, start_urd, start_uwr, u_last;
   assign is_data   = (alu_in == UART_DATA_ADDR);
   assign is_stat   = (alu_in == UART_STAT_ADDR);
   assign start_rd  = memread_in & ~is_data & ~is_stat;
   assign start_wr  = memwrite_in & ~memread_in & ~is_data & ~is_stat;
   assign start_urd = memread_in & is_data;
   assign start_uwr = memwrite_in & ~memread_in & is_data;
   assign start_any = start_rd | start_wr | start_urd | start_uwr;
   // Status reads finish in one cycle; status writes fall through as no-ops.
   assign pass_data = (memread_in & is_stat) ?
                      {{(DATA_W-2){1'b0}}, uart_data_ready, uart_tbre & uart_tsre} : alu_in;
`else
   assign start_rd  = memread_in;
   assign start_wr  = memwrite_in & ~memread_in;
   assign start_any = start_rd | start_wr;
   assign pass_data = alu_in;
`endif

   mem_sram_fsm u_fsm (
      .clk         (clk),
      .rst         (rst),
      .start_rd    (start_rd),
      .start_wr    (start_wr),
`ifdef MEM_UART_EN
      .start_urd   (start_urd),
      .start_uwr   (start_uwr),
      .u_last      (u_last),
      .uart_rdn    (uart_rdn),
      .uart_wrn    (uart_wrn),
`endif
      .state       (state),
      .mem_busy    (mem_busy),
      .ram_en_n    (ram_en_n),
      .ram_oe_n    (ram_oe_n),
      .ram_we_n    (ram_we_n),
      .ram_dout_oe (ram_dout_oe)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         addr_reg <= '0;
         data_reg <= '0;
         tag_reg  <= NO_REG;
         en_reg   <= 1'b0;
         wb_en    <= 1'b0;
         wb_data  <= '0;
         wb_reg   <= NO_REG;
      end else begin
         case (state)
            IDLE: begin
               if (start_any) begin
                  addr_reg <= alu_in;
                  data_reg <= wdata_in;
                  tag_reg  <= wreg_in;
                  en_reg   <= controlwb_in;
               end else begin
                  wb_en   <= controlwb_in;
                  wb_data <= pass_data;
                  wb_reg  <= wreg_in;
               end
            end
            RD_SAMPLE: begin
               wb_en   <= en_reg;
               wb_data <= ram_din;
               wb_reg  <= tag_reg;
            end
            WR_HOLD: begin
               wb_en   <= en_reg;
               wb_data <= addr_reg;
               wb_reg  <= tag_reg;
            end
`ifdef MEM_UART_EN
            U_RD: begin
               if (u_last) begin
                  wb_en   <= en_reg;
                  wb_data <= {{(DATA_W-8){1'b0}}, ram_din[7:0]};
                  wb_reg  <= tag_reg;
               end
            end
            U_WR: begin
               if (u_last) begin
                  wb_en   <= en_reg;
                  wb_data <= addr_reg;
                  wb_reg  <= tag_reg;
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign ram_addr = addr_reg[ADDR_W-1:0];
   assign ram_dout = data_reg;

endmodule

// File: doc/mem_access.md
# mem_access

Memory-access stage of the 16-bit pipeline, directly downstream of the EX/MEM register. Consumes its read/write strobes, ALU result (address or pass-through value), store data and write-back tag. Performs the access on the external data SRAM (and, optionally, the memory-mapped UART) through a small FSM, stalling the upstream pipeline while busy. Presents a registered result to the MEM/WB register.

## Interface
- `ADDR_W`, 16: SRAM address width.
- `DATA_W`, 16: data width.
- `clk` in 1: stage clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `memread_in` in 1: load request.
- `memwrite_in` in 1: store request.
- `controlwb_in` in 1: register write-back enable of the instruction.
- `alu_in` in 16: access address, or the result for non-memory ops.
- `wdata_in` in 16: store data.
- `wreg_in` in 4: destination register tag.
- `mem_busy` out 1: combinational stall to upstream; upstream holds all inputs while high.
- `wb_en` out 1: registered write-back enable.
- `wb_data` out 16: registered result (load data or `alu_in`).
- `wb_reg` out 4: registered destination tag.
- `ram_addr` out 16: SRAM address.
- `ram_dout` out 16: SRAM write data.
- `ram_din` in 16: SRAM read data.
- `ram_dout_oe` out 1: drive enable for the bidirectional bus, handled at top level.
- `ram_en_n`, `ram_oe_n`, `ram_we_n` out 1 each: SRAM strobes, active-low.
- `uart_rdn`, `uart_wrn` out 1 each: UART strobes, active-low. Present only with `MEM_UART_EN`.
- `uart_data_ready`, `uart_tbre`, `uart_tsre` in 1 each: UART status. Present only with `MEM_UART_EN`.

## Operation
- States:
  - `IDLE`
  - `RD_SETUP`
  - `RD_SAMPLE`
  - `WR_SETUP`
  - `WR_PULSE`
  - `WR_HOLD`
  - `U_RD`: UART read, with `MEM_UART_EN`
  - `U_WR`: UART write, with `MEM_UART_EN`
- `IDLE` with no request:
  - `wb_en <= controlwb_in`, `wb_data <= alu_in`, `wb_reg <= wreg_in`.
  - Stays `IDLE`; one-cycle pass-through.
- `IDLE` with request: `alu_in`/`wdata_in` are latched into internal registers, and the state goes to `RD_SETUP` or `WR_SETUP`.
  - `memread_in` and `memwrite_in` both high: read wins; the write is dropped.
- `RD_SETUP`:
  - `ram_en_n=0`, `ram_oe_n=0`, `ram_addr` = latched address.
  - Next state `RD_SAMPLE`.
- `RD_SAMPLE`:
  - Strobes held.
  - `wb_data <= ram_din`, `wb_reg`/`wb_en` from the latched tag/enable.
  - Next state `IDLE`.
- `WR_SETUP`:
  - `ram_en_n=0`, `ram_dout_oe=1`, `ram_dout` = latched data.
  - Next state `WR_PULSE`.
- `WR_PULSE`: `ram_we_n=0`; next state `WR_HOLD`.
- `WR_HOLD`:
  - `ram_we_n=1`; data and `en` held one cycle.
  - `wb_en <= controlwb_in` latched value.
  - Next state `IDLE`.
- `mem_busy = (IDLE & (memread_in|memwrite_in)) | RD_SETUP | WR_SETUP | WR_PULSE | U_RD | U_WR`.
  - Low in `RD_SAMPLE`/`WR_HOLD`, so upstream advances on that edge.
- Strobes deasserted (all `_n`=1, `ram_dout_oe`=0) in `IDLE`.

## Timing
- Reset values, applied at the first rising edge with `rst=1`:
  - State `IDLE`.
  - `wb_en=0`, `wb_data=0`, `wb_reg=4'b1111`.
  - `ram_en_n`, `ram_oe_n`, `ram_we_n` = 1; `ram_dout_oe=0`; `ram_addr=0`; `ram_dout=0`.
  - `uart_rdn`, `uart_wrn` = 1.
- `mem_busy` is 0 while `rst` is high.
- Reset mid-access: the access is aborted and strobes return high on that edge. The store is not guaranteed; no partial result reaches `wb_*`.
- Latency:
  - Non-memory: 1 cycle.
  - Load: 3 cycles (`IDLE`, `RD_SETUP`, `RD_SAMPLE`); `wb_*` is valid after the `RD_SAMPLE` edge.
  - Store: 4 cycles.
- Back-to-back accesses: each returns through `IDLE`, giving a minimum of 3 or 4 cycles per memory op.
- Address arithmetic: no translation; `ram_addr = alu_in[ADDR_W-1:0]`, and `ram_addr` wraps naturally.

## Configuration
- `MEM_UART_EN` defined:
  - Address `16'hBF00`:
    - Read: `U_RD`, `uart_rdn=0` for 2 cycles; `wb_data <= {8'h00, ram_din[7:0]}` sampled in the second cycle.
    - Write: `U_WR`, `uart_wrn=0` for 2 cycles with `ram_dout_oe=1`.
  - Address `16'hBF01`, read: single cycle, `wb_data <= {14'b0, uart_data_ready, uart_tbre & uart_tsre}`, no strobe.
  - Address `16'hBF01`, write: ignored.
  - SRAM strobes stay inactive for both UART addresses.
- `MEM_UART_EN` undefined: UART ports, `U_RD`/`U_WR` and the decode are absent. `16'hBF00`/`16'hBF01` are ordinary SRAM addresses.

## Structure
- Package `mem_pkg`:
  - State encoding (3-bit enum).
  - `UART_DATA_ADDR=16'hBF00`, `UART_STAT_ADDR=16'hBF01`.
  - `NO_REG=4'b1111`.
- One sub-module, `mem_sram_fsm`: state register, strobe generation, busy.
- The top `mem_access` holds the request latch, address decode, and `wb_*` registers.

## Test plan
- Reset held 2 cycles, then released, no request -> `wb_reg=4'hF`, `wb_en=0`, all strobes 1, `mem_busy=0`.
- Non-memory op `alu_in=16'h1234`, `wreg_in=3`, `controlwb_in=1` -> next edge `wb_data=16'h1234`, `wb_reg=3`, `wb_en=1`; `mem_busy` never high.
- Store `16'hBEEF` to `16'h0040`, then load `16'h0040` with SRAM model -> `ram_we_n` low exactly 1 cycle; load gives `wb_data=16'hBEEF` 3 cycles after request; `mem_busy` high 3 and 2 cycles respectively.
- Both `memread_in` and `memwrite_in` high at `16'h0010` -> read performed, `ram_we_n` stays 1.
- `rst` asserted during `WR_PULSE` -> next edge `ram_we_n=1`, `ram_en_n=1`, state `IDLE`, `wb_en=0`.
- With `MEM_UART_EN`, load `16'hBF01`, `uart_data_ready=1`, `uart_tbre=1`, `uart_tsre=1` -> `wb_data=16'h0003`; load `16'hBF00`, `ram_din=16'hFF41` -> `wb_data=16'h0041`, `ram_oe_n` stays 1.
